// File: rtl/zmips_pkg.sv
// Shared types and helpers for the zmips write-back path.
package zmips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int SB_W       = 30;
  localparam logic [REG_ADDR_W-1:0] PC_REG_LO = 5'd30;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  // Registers 30/31 are never written through this port.
  function automatic logic is_pc_reg(input logic [REG_ADDR_W-1:0] a);
    return a >= PC_REG_LO;
  endfunction

  // One-hot scoreboard mask; addresses 30/31 map to an empty mask.
  function automatic logic [SB_W-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] a);
    logic [SB_W-1:0] v;
    v = '0;
    for (int i = 0; i < SB_W; i++) begin
      if (a == REG_ADDR_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/zmips_wb_fifo.sv
// Long-latency result FIFO; with ZMIPS_WB_FWD_EN defined it also exposes
// every entry, ordered head (index 0) to tail, for forwarding.
module zmips_wb_fifo
  import zmips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
`ifdef ZMIPS_WB_FWD_EN
  , output wb_entry_t [DEPTH-1:0] view_entry
  , output logic [DEPTH-1:0]      view_valid
`endif
);

  localparam int AW = $clog2(DEPTH);

  wb_entry_t     mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   count;

  assign count = wr_ptr - rd_ptr;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

`ifdef ZMIPS_WB_FWD_EN
  always_comb begin
    view_entry = '0;
    view_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      view_entry[i] = mem[AW'(rd_ptr[AW-1:0] + AW'(i))];
      view_valid[i] = count > (AW+1)'(i);
    end
  end
`endif

endmodule

// File: rtl/zmips_wb_arbiter.sv
// Register-file write-back arbiter: ALU vs long-latency results, scoreboard,
// and optional forwarding enabled by defining ZMIPS_WB_FWD_EN.
module zmips_wb_arbiter
  import zmips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_addr,
  input  logic [31:0] alu_data,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_addr,
  input  logic [31:0] ll_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  input  logic [4:0]  rd_addr_0,
  input  logic [4:0]  rd_addr_1,
  output logic        busy_0,
  output logic        busy_1,
  output logic        stall,
  output logic        rf_wr,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data,
  output logic        wr_err,
  output logic        fwd_hit_0,
  output logic        fwd_hit_1,
  output logic [31:0] fwd_data_0,
  output logic [31:0] fwd_data_1
);

  wb_entry_t        head;
  wb_entry_t        src;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             load;
  logic             drop;
  logic [SB_W-1:0]  sb;
  logic [SB_W-1:0]  sb_set;
  logic [SB_W-1:0]  sb_clr;

`ifdef ZMIPS_WB_FWD_EN
  wb_entry_t [DEPTH-1:0] view_entry;
  logic [DEPTH-1:0]      view_valid;
`endif

  assign ll_ready = !fifo_full;
  assign stall    = fifo_full;
  assign push     = ll_valid && !fifo_full;
  assign pop      = !alu_valid && !fifo_empty;

  zmips_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry ('{addr: ll_addr, data: ll_data}),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
`ifdef ZMIPS_WB_FWD_EN
    , .view_entry (view_entry)
    , .view_valid (view_valid)
`endif
  );

  // ALU always wins the output stage; the FIFO head only moves when it loads.
  always_comb begin
    src    = '0;
    sb_set = '0;
    sb_clr = '0;
    if (alu_valid) src = '{addr: alu_addr, data: alu_data};
    else           src = head;
    load = alu_valid || !fifo_empty;
    drop = load && is_pc_reg(src.addr);
    if (iss_valid) sb_set = addr_onehot(iss_addr);
    if (pop)       sb_clr = addr_onehot(head.addr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wr      <= 1'b0;
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      wr_err     <= 1'b0;
      sb         <= '0;
    end else begin
      rf_wr  <= load && !drop;
      wr_err <= drop;
      if (load && !drop) begin
        rf_wr_addr <= src.addr;
        rf_wr_data <= src.data;
      end
      sb <= (sb & ~sb_clr) | sb_set;
    end
  end

  assign busy_0 = |(sb & addr_onehot(rd_addr_0));
  assign busy_1 = |(sb & addr_onehot(rd_addr_1));

`ifdef ZMIPS_WB_FWD_EN
  // Output register is oldest; later FIFO slots override earlier ones.
  function automatic logic [32:0] fwd_lookup(
    input logic [4:0]            a,
    input logic                  out_wr,
    input logic [4:0]            out_addr,
    input logic [31:0]           out_data,
    input wb_entry_t [DEPTH-1:0] ve,
    input logic [DEPTH-1:0]      vv
  );
    logic [32:0] r;
    r = '0;
    if (out_wr && out_addr == a) r = {1'b1, out_data};
    for (int i = 0; i < DEPTH; i++) begin
      if (vv[i] && ve[i].addr == a) r = {1'b1, ve[i].data};
    end
    return r;
  endfunction

  always_comb begin
    {fwd_hit_0, fwd_data_0} = fwd_lookup(rd_addr_0, rf_wr, rf_wr_addr, rf_wr_data,
                                         view_entry, view_valid);
    {fwd_hit_1, fwd_data_1} = fwd_lookup(rd_addr_1, rf_wr, rf_wr_addr, rf_wr_data,
                                         view_entry, view_valid);
  end
`else
  assign fwd_hit_0  = 1'b0;
  assign fwd_hit_1  = 1'b0;
  assign fwd_data_0 = '0;
  assign fwd_data_1 = '0;
`endif

  // A re-issue is only legal on the edge where the pending write commits.
  a_issue_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    iss_valid |-> !(|(sb & ~sb_clr & addr_onehot(iss_addr))));

  m_ll_hold: assume property (@(posedge clk) disable iff (!rst_n)
    ll_valid && !ll_ready |=> ll_valid && $stable(ll_addr) && $stable(ll_data));

endmodule

// File: tb/tb_zmips_wb_arbiter.sv
// Directed bench for zmips_wb_arbiter; forwarding expectations follow
// whether ZMIPS_WB_FWD_EN is defined.
module tb_zmips_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [4:0]  rd_addr_0;
  logic [4:0]  rd_addr_1;
  logic        busy_0;
  logic        busy_1;
  logic        stall;
  logic        rf_wr;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        wr_err;
  logic        fwd_hit_0;
  logic        fwd_hit_1;
  logic [31:0] fwd_data_0;
  logic [31:0] fwd_data_1;

  int tests_run = 0;
  int tests_failed = 0;

  zmips_wb_arbiter #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .ll_valid   (ll_valid),
    .ll_ready   (ll_ready),
    .ll_addr    (ll_addr),
    .ll_data    (ll_data),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .rd_addr_0  (rd_addr_0),
    .rd_addr_1  (rd_addr_1),
    .busy_0     (busy_0),
    .busy_1     (busy_1),
    .stall      (stall),
    .rf_wr      (rf_wr),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .wr_err     (wr_err),
    .fwd_hit_0  (fwd_hit_0),
    .fwd_hit_1  (fwd_hit_1),
    .fwd_data_0 (fwd_data_0),
    .fwd_data_1 (fwd_data_1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ll_valid = 1'b0;  ll_addr = '0;  ll_data = '0;
    iss_valid = 1'b0; iss_addr = '0;
    rd_addr_0 = '0;   rd_addr_1 = '0;
    tick();
    tick();
    check("rst_rf_wr", rf_wr, 0);
    check("rst_addr", rf_wr_addr, 0);
    check("rst_data", rf_wr_data, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_ll_ready", ll_ready, 1);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;
    tick();

    // ALU write, one-cycle latency
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
    tick();
    alu_valid = 1'b0;
    check("alu_rf_wr", rf_wr, 1);
    check("alu_addr", rf_wr_addr, 5);
    check("alu_data", rf_wr_data, 32'hDEADBEEF);
    rd_addr_0 = 5'd5; #1;
    check("no_fwd_after_alu_busy", busy_0, 0);
    tick();
    check("alu_idle", rf_wr, 0);

    // Issue 7, then LL commit of 7
    iss_valid = 1'b1; iss_addr = 5'd7;
    tick();
    iss_valid = 1'b0;
    rd_addr_0 = 5'd7; #1;
    check("busy7_set", busy_0, 1);
    ll_valid = 1'b1; ll_addr = 5'd7; ll_data = 32'h77;
    tick();
    ll_valid = 1'b0;
    check("ll_push_no_wr", rf_wr, 0);
    check("busy7_held", busy_0, 1);
    tick();
    check("ll_rf_wr", rf_wr, 1);
    check("ll_addr", rf_wr_addr, 7);
    check("ll_data", rf_wr_data, 32'h77);
    check("busy7_clr", busy_0, 0);
    tick();
    check("ll_idle", rf_wr, 0);

    // ALU busy 6 cycles while 4 LL pushes fill the FIFO
    for (int k = 0; k < 6; k++) begin
      alu_valid = 1'b1; alu_addr = 5'(10 + k); alu_data = 32'(k);
      ll_valid = (k < 4); ll_addr = 5'(20 + k); ll_data = 32'h100 + 32'(k);
      tick();
      check("fill_alu_addr", rf_wr_addr, 32'(10 + k));
      if (k == 2) check("ready_before_full", ll_ready, 1);
      if (k == 3) begin
        check("full_ready", ll_ready, 0);
        check("full_stall", stall, 1);
      end
    end
    alu_valid = 1'b0; ll_valid = 1'b0;
    check("still_full", stall, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("drain_wr", rf_wr, 1);
      check("drain_addr", rf_wr_addr, 32'(20 + k));
      check("drain_data", rf_wr_data, 32'h100 + 32'(k));
      if (k == 0) check("drain_ready", ll_ready, 1);
    end
    tick();
    check("drain_done", rf_wr, 0);

    // Writes to 31 (ALU) and 30 (LL) are dropped with wr_err
    alu_valid = 1'b1; alu_addr = 5'd31; alu_data = 32'h1;
    tick();
    alu_valid = 1'b0;
    check("r31_no_wr", rf_wr, 0);
    check("r31_err", wr_err, 1);
    tick();
    check("r31_err_pulse", wr_err, 0);
    iss_valid = 1'b1; iss_addr = 5'd30;
    ll_valid = 1'b1; ll_addr = 5'd30; ll_data = 32'h30;
    tick();
    iss_valid = 1'b0; ll_valid = 1'b0;
    rd_addr_0 = 5'd30; rd_addr_1 = 5'd29; #1;
    check("iss30_busy", busy_0, 0);
    check("iss30_nb29", busy_1, 0);
    tick();
    check("ll30_no_wr", rf_wr, 0);
    check("ll30_err", wr_err, 1);

    // Re-issue 9 on the edge its LL write commits: set wins
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    iss_valid = 1'b0;
    ll_valid = 1'b1; ll_addr = 5'd9; ll_data = 32'h99;
    tick();
    ll_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd9;
    rd_addr_0 = 5'd9;
    tick();
    iss_valid = 1'b0;
    check("reiss9_wr", rf_wr, 1);
    check("reiss9_addr", rf_wr_addr, 9);
    check("reiss9_busy", busy_0, 1);
    ll_valid = 1'b1; ll_data = 32'h9A;
    tick();
    ll_valid = 1'b0;
    tick();
    check("second9_data", rf_wr_data, 32'h9A);
    check("second9_busy", busy_0, 0);

    // Forwarding picture, then reset mid-drain
    iss_valid = 1'b1; iss_addr = 5'd12;
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h55;
    ll_valid = 1'b1; ll_addr = 5'd3; ll_data = 32'h11;
    tick();
    iss_valid = 1'b0;
    ll_data = 32'h22;
    tick();
    alu_valid = 1'b0; ll_valid = 1'b0;
    rd_addr_0 = 5'd1; rd_addr_1 = 5'd3; #1;
`ifdef ZMIPS_WB_FWD_EN
    check("fwd_out_hit", fwd_hit_0, 1);
    check("fwd_out_data", fwd_data_0, 32'h55);
    check("fwd_fifo_hit", fwd_hit_1, 1);
    check("fwd_young_data", fwd_data_1, 32'h22);
`else
    check("nofwd_hit0", fwd_hit_0, 0);
    check("nofwd_hit1", fwd_hit_1, 0);
    check("nofwd_data1", fwd_data_1, 0);
`endif
    tick();
    check("pop11_addr", rf_wr_addr, 3);
    check("pop11_data", rf_wr_data, 32'h11);
    rd_addr_0 = 5'd12; #1;
    check("busy12_set", busy_0, 1);
`ifdef ZMIPS_WB_FWD_EN
    check("fwd_fifo_over_out", fwd_data_1, 32'h22);
`endif
    rst_n = 1'b0; #1;
    check("mid_rst_wr", rf_wr, 0);
    check("mid_rst_addr", rf_wr_addr, 0);
    check("mid_rst_data", rf_wr_data, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_busy", busy_0, 0);
    check("mid_rst_fwd", fwd_hit_1, 0);
    tick();
    check("rst_cycle_wr", rf_wr, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_wr", rf_wr, 0);
    check("post_rst_fwd", fwd_hit_1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
